// File: rtl/apb_wdt_pkg.sv
// Shared constants and types for the APB watchdog timer: register offsets,
// reset/unlock values, CTRL bit positions and the write-strobe bundle.
package apb_wdt_pkg;

   localparam logic [11:0] WDT_LOAD   = 12'h000;
   localparam logic [11:0] WDT_VALUE  = 12'h004;
   localparam logic [11:0] WDT_CTRL   = 12'h008;
   localparam logic [11:0] WDT_INTCLR = 12'h00C;
   localparam logic [11:0] WDT_RIS    = 12'h010;
   localparam logic [11:0] WDT_MIS    = 12'h014;
   localparam logic [11:0] WDT_LOCK   = 12'hC00;

   localparam logic [31:0] WDT_LOAD_RST   = 32'hFFFF_FFFF;
   localparam logic [31:0] WDT_UNLOCK_KEY = 32'h1ACC_E551;

   localparam int CTRL_INTEN = 0;
   localparam int CTRL_RESEN = 1;

   // One-cycle commit strobes, already qualified by the lock.
   typedef struct packed {
      logic load;
      logic ctrl;
      logic intclr;
      logic lock;
   } wdt_wr_t;

endpackage

// File: rtl/apb_wdt_if.sv
// APB2-style bus segment between the AHB-to-APB bridge and the watchdog
// (no PREADY/PSLVERR; every transfer is exactly setup + access).
interface apb_wdt_if;

   logic        psel_wdt;
   logic        apb_xx_penable;
   logic        apb_xx_pwrite;
   logic [11:0] apb_xx_paddr;
   logic [31:0] apb_xx_pwdata;
   logic [31:0] prdata_wdt;

   modport master (
      output psel_wdt, apb_xx_penable, apb_xx_pwrite, apb_xx_paddr, apb_xx_pwdata,
      input  prdata_wdt
   );

   modport slave (
      input  psel_wdt, apb_xx_penable, apb_xx_pwrite, apb_xx_paddr, apb_xx_pwdata,
      output prdata_wdt
   );

endinterface

// File: rtl/apb_wdt_cnt.sv
// Watchdog down-counter: reload, expiry/RIS, registered interrupt and the
// sticky reset request raised by an expiry while RIS is still pending.
module apb_wdt_cnt #(
   parameter logic [31:0] LOAD_RST = 32'hFFFF_FFFF
) (
   input  logic        hclk,
   input  logic        hrst_b,
   input  logic        inten,
   input  logic        resen,
   input  logic [31:0] load_val,
   input  logic        load_wr,
   input  logic [31:0] load_data,
   input  logic        intclr,
   input  logic        start,
   output logic [31:0] value,
   output logic        ris,
   output logic        intr,
   output logic        rst_req
);

   logic        expiry;
   logic        rst_hit;
   logic [31:0] value_nxt;

   assign expiry = inten & (value == 32'd0);

   // Clear beats expiry; a LOAD write beats the automatic reload.
   always_comb begin
      // NOTE: default assignment first so no path leaves value_nxt unassigned (no latch).
      value_nxt = value;
      if (intclr)
         value_nxt = load_val;
      else if (load_wr)
         value_nxt = load_data;
      else if (start || expiry)
         value_nxt = load_val;
      else if (inten)
         value_nxt = value - 32'd1;
   end

   // NOTE: non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge hclk or negedge hrst_b) begin
      if (!hrst_b) begin
         value   <= LOAD_RST;
         ris     <= 1'b0;
         rst_hit <= 1'b0;
         rst_req <= 1'b0;
         intr    <= 1'b0;
      end else begin
         value <= value_nxt;
         if (intclr)
            ris <= 1'b0;
         else if (expiry)
            ris <= 1'b1;
         rst_hit <= expiry & ris & resen & ~intclr;
         if (rst_hit)
            rst_req <= 1'b1;
         intr <= ris & inten;
      end
   end

endmodule

// File: rtl/apb_wdt.sv
// APB watchdog top: register file, write lock and read capture on the setup
// edge; the counting itself lives in apb_wdt_cnt.
module apb_wdt
   import apb_wdt_pkg::*;
#(
   parameter logic [31:0] LOAD_RST   = WDT_LOAD_RST,
   parameter logic [31:0] UNLOCK_KEY = WDT_UNLOCK_KEY
) (
   input  logic      hclk,
   input  logic      hrst_b,
   apb_wdt_if.slave  apb,
   output logic      wdt_intr,
   output logic      wdt_rst_req
);

   logic        setup;
   logic        wr_en;
   logic [11:0] off;
   wdt_wr_t     wr;
   logic [31:0] load_q;
   logic        inten;
   logic        resen;
   logic        locked;
   logic        start;
   logic [31:0] value;
   logic        ris;
   logic [31:0] rdata;

   assign setup = apb.psel_wdt & ~apb.apb_xx_penable;
   assign wr_en = apb.psel_wdt & apb.apb_xx_penable & apb.apb_xx_pwrite;
   assign off   = {apb.apb_xx_paddr[11:2], 2'b00};

   always_comb begin
      wr = '0;
      if (wr_en) begin
         unique case (off)
            WDT_LOAD:   wr.load   = ~locked;
            WDT_CTRL:   wr.ctrl   = ~locked;
            WDT_INTCLR: wr.intclr = ~locked;
            WDT_LOCK:   wr.lock   = 1'b1;
            default:    ;
         endcase
      end
   end

   // Only a 0->1 INTEN transition reloads the counter.
   assign start = wr.ctrl & apb.apb_xx_pwdata[CTRL_INTEN] & ~inten;

   always_ff @(posedge hclk or negedge hrst_b) begin
      if (!hrst_b) begin
         load_q <= LOAD_RST;
         inten  <= 1'b0;
         resen  <= 1'b0;
         locked <= 1'b0;
      end else begin
         if (wr.load)
            load_q <= apb.apb_xx_pwdata;
         if (wr.ctrl) begin
            inten <= apb.apb_xx_pwdata[CTRL_INTEN];
            resen <= apb.apb_xx_pwdata[CTRL_RESEN];
         end
         if (wr.lock)
            locked <= (apb.apb_xx_pwdata != UNLOCK_KEY);
      end
   end

   apb_wdt_cnt #(.LOAD_RST(LOAD_RST)) u_cnt (
      .hclk      (hclk),
      .hrst_b    (hrst_b),
      .inten     (inten),
      .resen     (resen),
      .load_val  (load_q),
      .load_wr   (wr.load),
      .load_data (apb.apb_xx_pwdata),
      .intclr    (wr.intclr),
      .start     (start),
      .value     (value),
      .ris       (ris),
      .intr      (wdt_intr),
      .rst_req   (wdt_rst_req)
   );

   always_comb begin
      rdata = '0;
      unique case (off)
         WDT_LOAD:  rdata = load_q;
         WDT_VALUE: rdata = value;
         WDT_CTRL:  rdata = {30'd0, resen, inten};
         WDT_RIS:   rdata = {31'd0, ris};
         WDT_MIS:   rdata = {31'd0, ris & inten};
         WDT_LOCK:  rdata = {31'd0, locked};
         default:   rdata = '0;
      endcase
   end

   // Captured at the setup edge so data is stable for the whole access cycle.
   always_ff @(posedge hclk or negedge hrst_b) begin
      if (!hrst_b)
         apb.prdata_wdt <= '0;
      else if (setup && !apb.apb_xx_pwrite)
         apb.prdata_wdt <= rdata;
   end

endmodule

// File: tb/tb_apb_wdt.sv
// Directed bench for apb_wdt: a register-map vector table run back-to-back,
// then hand-timed sequences for expiry, reset request, lock and reset races.
module tb_apb_wdt;
   import apb_wdt_pkg::*;

   logic hclk = 1'b0;
   logic hrst_b = 1'b0;
   logic wdt_intr;
   logic wdt_rst_req;

   apb_wdt_if bus ();

   apb_wdt dut (
      .hclk        (hclk),
      .hrst_b      (hrst_b),
      .apb         (bus),
      .wdt_intr    (wdt_intr),
      .wdt_rst_req (wdt_rst_req)
   );

   always #5 hclk = ~hclk;

   int checks = 0;
   int failures = 0;
   logic [31:0] rd;

   typedef struct {
      bit          wr;
      logic [11:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
      string       name;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bus_idle();
      bus.psel_wdt       = 1'b0;
      bus.apb_xx_penable = 1'b0;
      bus.apb_xx_pwrite  = 1'b0;
      bus.apb_xx_paddr   = '0;
      bus.apb_xx_pwdata  = '0;
   endtask

   // Called at a negedge: setup now, access next negedge, return one cycle later.
   task automatic xfer(input bit wr, input logic [11:0] addr, input logic [31:0] data,
                       input bit b2b, output logic [31:0] rdata);
      bus.psel_wdt       = 1'b1;
      bus.apb_xx_penable = 1'b0;
      bus.apb_xx_pwrite  = wr;
      bus.apb_xx_paddr   = addr;
      bus.apb_xx_pwdata  = data;
      @(negedge hclk);
      bus.apb_xx_penable = 1'b1;
      rdata = bus.prdata_wdt;
      @(negedge hclk);
      if (!b2b) bus_idle();
   endtask

   task automatic wr_reg(input logic [11:0] addr, input logic [31:0] data);
      logic [31:0] unused;
      xfer(1'b1, addr, data, 1'b0, unused);
   endtask

   task automatic rd_reg(input logic [11:0] addr, output logic [31:0] data);
      xfer(1'b0, addr, 32'd0, 1'b0, data);
   endtask

   initial begin
      vecs[0]  = '{1'b0, WDT_LOAD,   32'd0,          32'hFFFF_FFFF, "rst_load"};
      vecs[1]  = '{1'b0, WDT_VALUE,  32'd0,          32'hFFFF_FFFF, "rst_value"};
      vecs[2]  = '{1'b0, WDT_CTRL,   32'd0,          32'd0,         "rst_ctrl"};
      vecs[3]  = '{1'b0, WDT_INTCLR, 32'd0,          32'd0,         "rd_intclr"};
      vecs[4]  = '{1'b0, WDT_RIS,    32'd0,          32'd0,         "rst_ris"};
      vecs[5]  = '{1'b0, WDT_MIS,    32'd0,          32'd0,         "rst_mis"};
      vecs[6]  = '{1'b0, WDT_LOCK,   32'd0,          32'd0,         "rst_lock"};
      vecs[7]  = '{1'b0, 12'h018,    32'd0,          32'd0,         "unmapped_rd"};
      vecs[8]  = '{1'b1, WDT_CTRL,   32'hFFFF_FFFE,  32'd0,         ""};
      vecs[9]  = '{1'b0, WDT_CTRL,   32'd0,          32'd2,         "ctrl_resen_only"};
      vecs[10] = '{1'b1, WDT_LOAD,   32'h1234_5678,  32'd0,         ""};
      vecs[11] = '{1'b0, 12'h006,    32'd0,          32'h1234_5678, "value_stop_reload"};
      vecs[12] = '{1'b0, WDT_LOAD,   32'd0,          32'h1234_5678, "load_rw"};
      vecs[13] = '{1'b1, 12'h01C,    32'hDEAD_BEEF,  32'd0,         ""};
      vecs[14] = '{1'b0, 12'h01C,    32'd0,          32'd0,         "unmapped_wr"};
      vecs[15] = '{1'b1, WDT_CTRL,   32'd0,          32'd0,         ""};
      vecs[16] = '{1'b0, 12'h00B,    32'd0,          32'd0,         "ctrl_cleared"};

      bus_idle();
      repeat (2) @(negedge hclk);
      check("rst_prdata", bus.prdata_wdt, 32'd0);
      check("rst_intr", {31'd0, wdt_intr}, 32'd0);
      check("rst_req_init", {31'd0, wdt_rst_req}, 32'd0);
      hrst_b = 1'b1;
      @(negedge hclk);

      // Register map, all transfers back-to-back.
      for (int i = 0; i < NVEC; i++) begin
         xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, i != NVEC - 1, rd);
         if (!vecs[i].wr) check(vecs[i].name, rd, vecs[i].exp);
      end
      check("table_intr", {31'd0, wdt_intr}, 32'd0);

      // LOAD=5, start: intr rises on the 7th edge after the CTRL commit.
      wr_reg(WDT_LOAD, 32'd5);
      wr_reg(WDT_CTRL, 32'd1);
      repeat (6) @(negedge hclk);
      check("intr_before_expiry", {31'd0, wdt_intr}, 32'd0);
      rd_reg(WDT_VALUE, rd);
      check("value_after_expiry", rd, 32'd5);
      check("intr_after_expiry", {31'd0, wdt_intr}, 32'd1);

      // RESEN with RIS pending: second expiry raises the reset request.
      wr_reg(WDT_CTRL, 32'd3);
      check("rst_req_pre", {31'd0, wdt_rst_req}, 32'd0);
      @(negedge hclk);
      check("rst_req_pre2", {31'd0, wdt_rst_req}, 32'd0);
      repeat (3) @(negedge hclk);
      check("rst_req_set", {31'd0, wdt_rst_req}, 32'd1);
      wr_reg(WDT_INTCLR, 32'h0);
      rd_reg(WDT_RIS, rd);
      check("ris_cleared", rd, 32'd0);
      check("rst_req_sticky", {31'd0, wdt_rst_req}, 32'd1);

      // Lock.
      wr_reg(WDT_LOCK, 32'd0);
      wr_reg(WDT_LOAD, 32'd9);
      rd_reg(WDT_LOAD, rd);
      check("load_locked", rd, 32'd5);
      rd_reg(WDT_LOCK, rd);
      check("lock_set", rd, 32'd1);
      wr_reg(WDT_LOCK, WDT_UNLOCK_KEY);
      wr_reg(WDT_LOAD, 32'd9);
      rd_reg(WDT_LOAD, rd);
      check("load_unlocked", rd, 32'd9);
      rd_reg(WDT_LOCK, rd);
      check("lock_clear", rd, 32'd0);

      // Reset, then INTCLR committing exactly on the second expiry.
      hrst_b = 1'b0;
      bus_idle();
      @(negedge hclk);
      check("rst_req_reset", {31'd0, wdt_rst_req}, 32'd0);
      hrst_b = 1'b1;
      @(negedge hclk);
      wr_reg(WDT_LOAD, 32'd3);
      wr_reg(WDT_CTRL, 32'd3);
      repeat (6) @(negedge hclk);
      check("ris_pending", {31'd0, wdt_intr}, 32'd1);
      wr_reg(WDT_INTCLR, 32'hA5A5_A5A5);
      rd_reg(WDT_RIS, rd);
      check("clear_wins_ris", rd, 32'd0);
      check("clear_wins_req", {31'd0, wdt_rst_req}, 32'd0);
      repeat (3) @(negedge hclk);
      check("clear_wins_req2", {31'd0, wdt_rst_req}, 32'd0);

      // Reset asserted in the access cycle of a RIS read.
      bus.psel_wdt       = 1'b1;
      bus.apb_xx_penable = 1'b0;
      bus.apb_xx_pwrite  = 1'b0;
      bus.apb_xx_paddr   = WDT_RIS;
      @(negedge hclk);
      bus.apb_xx_penable = 1'b1;
      #2;
      check("pre_rst_prdata", bus.prdata_wdt, 32'd1);
      check("pre_rst_intr", {31'd0, wdt_intr}, 32'd1);
      hrst_b = 1'b0;
      #1;
      check("midrst_prdata", bus.prdata_wdt, 32'd0);
      check("midrst_intr", {31'd0, wdt_intr}, 32'd0);
      check("midrst_req", {31'd0, wdt_rst_req}, 32'd0);
      @(negedge hclk);
      bus_idle();
      @(negedge hclk);
      hrst_b = 1'b1;
      rd_reg(WDT_CTRL, rd);
      check("ctrl_after_rst", rd, 32'd0);
      rd_reg(WDT_RIS, rd);
      check("ris_after_rst", rd, 32'd0);

      // LOAD=0 expires every cycle; LOAD write during expiry takes new data.
      wr_reg(WDT_LOAD, 32'd0);
      wr_reg(WDT_CTRL, 32'd1);
      rd_reg(WDT_VALUE, rd);
      check("load0_value", rd, 32'd0);
      rd_reg(WDT_MIS, rd);
      check("load0_mis", rd, 32'd1);
      wr_reg(WDT_LOAD, 32'd7);
      rd_reg(WDT_VALUE, rd);
      check("load_on_expiry", rd, 32'd7);
      check("load0_no_req", {31'd0, wdt_rst_req}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apb_wdt.md
# apb_wdt

APB watchdog timer: a responder on the APB segment driven by the AHB-to-APB bridge, selected by that bridge's NMI_WAKE/spare window decode (base 0x4001B000, 4 KB). It provides a reloadable 32-bit down-counter, a level interrupt on first expiry, and a sticky reset request on a second expiry with the interrupt still pending. It uses the bridge's APB2-style timing: no PREADY, no PSLVERR, fixed two-cycle transfers.

## Interface
- `LOAD_RST`, 32'hFFFF_FFFF, reset value of LOAD.
- `UNLOCK_KEY`, 32'h1ACC_E551, value written to LOCK that clears the lock.
- `hclk` in 1: the single clock.
- `hrst_b` in 1: reset, asynchronous and active-low.
- `psel_wdt` in 1: slave select from bridge decode.
- `apb_xx_penable` in 1: APB access phase.
- `apb_xx_pwrite` in 1: 1 = write.
- `apb_xx_paddr` in 12: byte offset `[11:0]`; bits `[1:0]` ignored.
- `apb_xx_pwdata` in 32: write data.
- `prdata_wdt` out 32: read data; registered.
- `wdt_intr` out 1: interrupt = RIS & INTEN; registered.
- `wdt_rst_req` out 1: system reset request; sticky until `hrst_b`.

## Operation
- Transfer qualifiers:
  - setup = `psel_wdt & !apb_xx_penable`.
  - access = `psel_wdt & apb_xx_penable`.
- Writes commit on the access cycle edge.
- Reads are captured into `prdata_wdt` on the setup cycle edge, so data is valid throughout the access cycle. `prdata_wdt` holds its value otherwise.
- Register map (offset, access, reset):
  - 0x000 LOAD, RW, `LOAD_RST`.
  - 0x004 VALUE, RO, `LOAD_RST`: live count.
  - 0x008 CTRL, RW, 0: bit0 INTEN, bit1 RESEN, other bits read 0.
  - 0x00C INTCLR, WO: any data value clears RIS and reloads the counter. Reads return 0.
  - 0x010 RIS, RO, 0: bit0.
  - 0x014 MIS, RO, 0: bit0 = RIS & INTEN.
  - 0xC00 LOCK, RW, 0: writing `UNLOCK_KEY` clears the lock; writing any other value sets it. Reads return {31'b0, locked}.
  - Unmapped offsets: reads return 0, writes are ignored.
- While locked, writes to LOAD, CTRL and INTCLR are ignored. LOCK is always writable.
- Counter states: STOP (INTEN=0) and RUN (INTEN=1).
  - STOP: VALUE holds.
  - STOP→RUN (INTEN written 0→1): VALUE ← LOAD on the following edge.
  - RUN, VALUE≠0: decrement by 1 per `hclk`.
  - RUN, VALUE==0 (expiry): VALUE ← LOAD and RIS ← 1.
  - Expiry while RIS is already 1 and RESEN=1: `wdt_rst_req` ← 1.
- A LOAD write reloads VALUE with the new data on the commit edge, in both STOP and RUN.
- LOAD = 0 gives an expiry on every RUN cycle.
- Simultaneous events:
  - INTCLR commit in the same cycle as expiry: clear wins. RIS = 0, VALUE ← LOAD, no reset request.
  - LOAD write in the same cycle as expiry: RIS ← 1 and VALUE ← new LOAD data.
- `wdt_rst_req` is cleared only by `hrst_b`. The counter keeps running after it asserts.
- Reset mid-transfer: all state returns to its reset value immediately, and the partial transfer is lost.

## Timing
- Output reset values: `prdata_wdt`=0, `wdt_intr`=0, `wdt_rst_req`=0.
- Write-to-effect latency: 1 edge after the access cycle (the register value is visible from the next cycle).
- Interrupt latency: expiry edge sets RIS, and `wdt_intr` follows on the next edge.
- Reset-request latency: `wdt_rst_req` asserts on the next edge after the second expiry.
- VALUE read race: the value read is the one sampled at the setup edge, which is one count above the value at the access cycle.
- The slave never stalls. Back-to-back transfers (access followed directly by the next setup) must work.

## Structure
- Shared package `apb_wdt_pkg`:
  - register offset constants `WDT_LOAD`…`WDT_LOCK`;
  - the default unlock key;
  - CTRL bit index constants.
- Sub-module `apb_wdt_cnt`: the 32-bit counter, reload, expiry/RIS and reset-request logic.
- Top level: the APB register file, lock, and read mux/capture.
- Target size is about 200 lines of RTL.

## Test plan
- Reset, then read every register: LOAD=VALUE=FFFF_FFFF, all others 0; `wdt_intr`=`wdt_rst_req`=0.
- Write LOAD=5, then CTRL=1: `wdt_intr` rises 7 cycles after the CTRL commit (reload, 5 decrements, expiry edge, output edge), and VALUE reads back 5 afterwards.
- Continue the previous case with CTRL=3 and no INTCLR: `wdt_rst_req`=1 after the second expiry, and it stays 1 after a further INTCLR write.
- Write LOCK=0, then LOAD=9: LOAD still reads 5 and LOCK reads 1. Write LOCK=1ACC_E551, then LOAD=9: LOAD reads 9.
- Schedule an INTCLR commit on exactly the expiry cycle with RESEN=1 and RIS=1: RIS reads 0 and `wdt_rst_req` stays 0.
- Assert `hrst_b` during a read's access cycle with RIS=1: all outputs 0 immediately, and CTRL reads 0 after reset is released.
